// File: rtl/zigzag_rle_encoder.sv
// Captures a quantized 8x8 block, rescans it in zigzag order and emits (run, value) symbols with ZRL/EOB.
// Optional build macro ZZ_DC_DPCM_EN: DC symbol carries the difference from the previous block's DC.
module zigzag_rle_encoder #(
  parameter int COEFF_W     = 16,
  parameter int NUM_SAMPLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_SAMPLES*COEFF_W-1:0] quant_in,
  input  logic                           quant_valid,
  output logic                           in_ready,
  output logic                           overrun,
  output logic                           sym_valid,
  input  logic                           sym_ready,
  output logic [3:0]                     sym_run,
  output logic [COEFF_W-1:0]             sym_value,
  output logic                           sym_dc,
  output logic                           sym_eob,
  output logic                           sym_last,
  output logic                           done,
  output logic                           busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EOB  = 2'd2
  } state_t;

  localparam int ZZ_MAP [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  state_t state_reg, state_next;

  logic [COEFF_W-1:0]     coef_reg [NUM_SAMPLES];
  logic [NUM_SAMPLES-1:0] nz_in;
  logic [NUM_SAMPLES-1:0] nz_mask_reg;
  logic [5:0]             lnz_in, lnz_reg;
  logic                   any_nz_in, any_nz_reg;
  logic [5:0]             zz_reg;
  logic [3:0]             run_reg, run_next;

  logic                   sym_valid_reg, sym_dc_reg, sym_eob_reg, sym_last_reg;
  logic [3:0]             sym_run_reg;
  logic [COEFF_W-1:0]     sym_value_reg;
  logic                   overrun_reg, done_reg, busy_reg;

  logic                   capture, free, last_acc, step, eob_step;
  logic                   cur_nz, at_end, last_here, zrl;
  logic [COEFF_W-1:0]     cur_val, dc_value;

  logic                   emit, emit_dc, emit_eob, emit_last;
  logic [3:0]             emit_run;
  logic [COEFF_W-1:0]     emit_val;

  assign in_ready = rst_n && (state_reg == S_IDLE);
  assign capture  = quant_valid && in_ready;
  // The output register may take a new symbol unless it holds an unaccepted one or the final one.
  assign free     = !sym_valid_reg || (sym_ready && !sym_last_reg);
  assign last_acc = sym_valid_reg && sym_ready && sym_last_reg;
  assign step     = (state_reg == S_SCAN) && enable && free;
  assign eob_step = (state_reg == S_EOB) && enable && free;

  assign cur_nz    = nz_mask_reg[zz_reg];
  assign cur_val   = coef_reg[zz_reg];
  assign at_end    = any_nz_reg ? (zz_reg == lnz_reg) : (zz_reg == 6'd0);
  assign last_here = any_nz_reg && (lnz_reg == 6'd63) && at_end;
  assign zrl       = (zz_reg < lnz_reg) && (run_reg == 4'd15);

  generate
    for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_nz
      assign nz_in[gi] = |quant_in[ZZ_MAP[gi]*COEFF_W +: COEFF_W];
    end
  endgenerate

  always_comb begin
    lnz_in    = 6'd0;
    any_nz_in = 1'b0;
    for (int i = 1; i < NUM_SAMPLES; i++) begin
      if (nz_in[i]) begin
        lnz_in    = 6'(i);
        any_nz_in = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        coef_reg[i] <= quant_in[ZZ_MAP[i]*COEFF_W +: COEFF_W];
      end
    end
  end

`ifdef ZZ_DC_DPCM_EN
  logic [COEFF_W-1:0] pred_reg;

  assign dc_value = coef_reg[0] - pred_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_reg <= '0;
    end else if (sym_valid_reg && sym_ready && sym_dc_reg) begin
      pred_reg <= coef_reg[0];
    end
  end
`else
  assign dc_value = coef_reg[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (capture) state_next = S_SCAN;
      S_SCAN: begin
        if (last_acc) state_next = S_IDLE;
        else if (step && at_end && !last_here) state_next = S_EOB;
      end
      S_EOB:  if (last_acc) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_run  = 4'd0;
    emit_val  = '0;
    emit_dc   = 1'b0;
    emit_eob  = 1'b0;
    emit_last = 1'b0;
    run_next  = run_reg;
    if (step) begin
      if (zz_reg == 6'd0) begin
        emit      = 1'b1;
        emit_dc   = 1'b1;
        emit_val  = dc_value;
        emit_last = last_here;
      end else if (cur_nz) begin
        emit      = 1'b1;
        emit_run  = run_reg;
        emit_val  = cur_val;
        emit_last = last_here;
        run_next  = 4'd0;
      end else if (zrl) begin
        emit     = 1'b1;
        emit_run = 4'd15;
        run_next = 4'd0;
      end else begin
        run_next = run_reg + 4'd1;
      end
    end else if (eob_step) begin
      emit      = 1'b1;
      emit_eob  = 1'b1;
      emit_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_mask_reg   <= '0;
      lnz_reg       <= 6'd0;
      any_nz_reg    <= 1'b0;
      zz_reg        <= 6'd0;
      run_reg       <= 4'd0;
      sym_valid_reg <= 1'b0;
      sym_run_reg   <= 4'd0;
      sym_value_reg <= '0;
      sym_dc_reg    <= 1'b0;
      sym_eob_reg   <= 1'b0;
      sym_last_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      overrun_reg <= quant_valid && !in_ready;
      done_reg    <= last_acc;
      if (capture) begin
        nz_mask_reg <= nz_in;
        lnz_reg     <= lnz_in;
        any_nz_reg  <= any_nz_in;
        zz_reg      <= 6'd0;
        run_reg     <= 4'd0;
        busy_reg    <= 1'b1;
      end else begin
        run_reg <= run_next;
        if (step && !at_end) zz_reg <= zz_reg + 6'd1;
      end
      if (last_acc) busy_reg <= 1'b0;
      if (sym_valid_reg && sym_ready) sym_valid_reg <= 1'b0;
      if (emit) begin
        sym_valid_reg <= 1'b1;
        sym_run_reg   <= emit_run;
        sym_value_reg <= emit_val;
        sym_dc_reg    <= emit_dc;
        sym_eob_reg   <= emit_eob;
        sym_last_reg  <= emit_last;
      end
    end
  end

  assign overrun   = overrun_reg;
  assign sym_valid = sym_valid_reg;
  assign sym_run   = sym_run_reg;
  assign sym_value = sym_value_reg;
  assign sym_dc    = sym_dc_reg;
  assign sym_eob   = sym_eob_reg;
  assign sym_last  = sym_last_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Directed bench for zigzag_rle_encoder; DC expectations follow ZZ_DC_DPCM_EN when it is defined.
module tb_zigzag_rle_encoder;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [1023:0] quant_in;
  logic          quant_valid;
  logic          in_ready;
  logic          overrun;
  logic          sym_valid;
  logic          sym_ready;
  logic [3:0]    sym_run;
  logic [15:0]   sym_value;
  logic          sym_dc;
  logic          sym_eob;
  logic          sym_last;
  logic          done;
  logic          busy;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [1023:0] blk;
  logic [15:0]   e;
`ifdef ZZ_DC_DPCM_EN
  logic [15:0]   tb_pred = 16'd0;
`endif

  zigzag_rle_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .quant_in    (quant_in),
    .quant_valid (quant_valid),
    .in_ready    (in_ready),
    .overrun     (overrun),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_run     (sym_run),
    .sym_value   (sym_value),
    .sym_dc      (sym_dc),
    .sym_eob     (sym_eob),
    .sym_last    (sym_last),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_dc(input logic [15:0] dc, output logic [15:0] ev);
`ifdef ZZ_DC_DPCM_EN
    ev = dc - tb_pred;
    tb_pred = dc;
`else
    ev = dc;
`endif
  endtask

  task automatic set_lane(input int i, input logic [15:0] v);
    blk[i*16 +: 16] = v;
  endtask

  // Called on a negedge; capture happens at the following posedge.
  task automatic send_block();
    quant_in    = blk;
    quant_valid = 1'b1;
    @(negedge clk);
    quant_valid = 1'b0;
  endtask

  task automatic expect_sym(input string tag, input logic [3:0] r, input logic [15:0] v,
                            input logic dc, input logic eob, input logic last);
    int k = 0;
    @(negedge clk);
    while (!sym_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".valid"}, 32'(sym_valid), 32'd1);
    chk({tag, ".run"},   32'(sym_run),   32'(r));
    chk({tag, ".value"}, 32'(sym_value), 32'(v));
    chk({tag, ".dc"},    32'(sym_dc),    32'(dc));
    chk({tag, ".eob"},   32'(sym_eob),   32'(eob));
    chk({tag, ".last"},  32'(sym_last),  32'(last));
    $display("sym %s run=%0d value=%0d dc=%0b eob=%0b last=%0b",
             tag, sym_run, $signed(sym_value), sym_dc, sym_eob, sym_last);
  endtask

  task automatic wait_done(input string tag);
    @(negedge clk);
    chk({tag, ".done"},     32'(done),     32'd1);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    $display("done %s", tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    quant_in    = '0;
    quant_valid = 1'b0;
    sym_ready   = 1'b1;
    blk         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.sym_valid", 32'(sym_valid), 32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.done",      32'(done),      32'd0);
    chk("rst.overrun",   32'(overrun),   32'd0);
    chk("rst.sym_value", 32'(sym_value), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    // All-zero block
    blk = '0;
    send_block();
    chk("zero.busy",      32'(busy),      32'd1);
    chk("zero.latency",   32'(sym_valid), 32'd0);
    next_dc(16'd0, e);
    expect_sym("zero.dc",  4'd0, e,     1'b1, 1'b0, 1'b0);
    expect_sym("zero.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("zero");
    @(negedge clk);
    chk("zero.done_pulse", 32'(done), 32'd0);

    // DC 50, (0,-3), (0,7), EOB
    blk = '0;
    set_lane(0, 16'd50);
    set_lane(1, -16'sd3);
    set_lane(8, 16'd7);
    send_block();
    next_dc(16'd50, e);
    expect_sym("b3.dc",  4'd0, e,      1'b1, 1'b0, 1'b0);
    expect_sym("b3.s1",  4'd0, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    expect_sym("b3.s2",  4'd0, 16'd7,  1'b0, 1'b0, 1'b0);
    expect_sym("b3.eob", 4'd0, 16'd0,  1'b0, 1'b1, 1'b1);
    wait_done("b3");

    // Only lane 63: DC 0, ZRL x3, (14,5,last), no EOB
    @(negedge clk);
    blk = '0;
    set_lane(63, 16'd5);
    send_block();
    next_dc(16'd0, e);
    expect_sym("l63.dc",   4'd0,  e,     1'b1, 1'b0, 1'b0);
    expect_sym("l63.zrl1", 4'd15, 16'd0, 1'b0, 1'b0, 1'b0);
    expect_sym("l63.zrl2", 4'd15, 16'd0, 1'b0, 1'b0, 1'b0);
    expect_sym("l63.zrl3", 4'd15, 16'd0, 1'b0, 1'b0, 1'b0);
    expect_sym("l63.last", 4'd14, 16'd5, 1'b0, 1'b0, 1'b1);
    wait_done("l63");

    // Backpressure on the second symbol for 5 cycles
    @(negedge clk);
    blk = '0;
    set_lane(0, 16'd1);
    set_lane(1, 16'd2);
    set_lane(8, 16'd3);
    sym_ready = 1'b0;
    send_block();
    next_dc(16'd1, e);
    @(negedge clk);
    chk("stall.dc_valid", 32'(sym_valid), 32'd1);
    chk("stall.dc_value", 32'(sym_value), 32'(e));
    sym_ready = 1'b1;
    @(negedge clk);
    chk("stall.s1_valid", 32'(sym_valid), 32'd1);
    chk("stall.s1_dc",    32'(sym_dc),    32'd0);
    sym_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.hold_valid", 32'(sym_valid), 32'd1);
      chk("stall.hold_value", 32'(sym_value), 32'd2);
      chk("stall.hold_run",   32'(sym_run),   32'd0);
    end
    sym_ready = 1'b1;
    expect_sym("stall.s2",  4'd0, 16'd3, 1'b0, 1'b0, 1'b0);
    expect_sym("stall.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("stall");

    // quant_valid while busy
    @(negedge clk);
    blk = '0;
    set_lane(0, 16'd7);
    sym_ready = 1'b0;
    send_block();
    blk = '0;
    set_lane(0, 16'd99);
    set_lane(5, 16'd1);
    quant_in    = blk;
    quant_valid = 1'b1;
    @(negedge clk);
    quant_valid = 1'b0;
    chk("ovr.pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    chk("ovr.pulse_end", 32'(overrun), 32'd0);
    next_dc(16'd7, e);
    chk("ovr.dc_value", 32'(sym_value), 32'(e));
    chk("ovr.dc_flag",  32'(sym_dc),    32'd1);
    sym_ready = 1'b1;
    expect_sym("ovr.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("ovr");

    // DC 100 then 90; second block captured in the done cycle
    @(negedge clk);
    blk = '0;
    set_lane(0, 16'd100);
    send_block();
    next_dc(16'd100, e);
    expect_sym("dcA.dc",  4'd0, e,     1'b1, 1'b0, 1'b0);
    expect_sym("dcA.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("dcA");
    blk = '0;
    set_lane(0, 16'd90);
    send_block();
    chk("dcB.busy", 32'(busy), 32'd1);
`ifdef ZZ_DC_DPCM_EN
    expect_sym("dcB.dc", 4'd0, 16'hFFF6, 1'b1, 1'b0, 1'b0);
    tb_pred = 16'd90;
`else
    expect_sym("dcB.dc", 4'd0, 16'd90, 1'b1, 1'b0, 1'b0);
`endif
    expect_sym("dcB.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("dcB");

    // Reset in the middle of a long scan
    @(negedge clk);
    blk = '0;
    set_lane(0, 16'd33);
    set_lane(63, 16'd5);
    send_block();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.sym_valid", 32'(sym_valid), 32'd0);
    chk("mrst.busy",      32'(busy),      32'd0);
    chk("mrst.sym_run",   32'(sym_run),   32'd0);
    chk("mrst.sym_value", 32'(sym_value), 32'd0);
    chk("mrst.in_ready",  32'(in_ready),  32'd0);
`ifdef ZZ_DC_DPCM_EN
    tb_pred = 16'd0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst.in_ready_after", 32'(in_ready), 32'd1);
    blk = '0;
    set_lane(0, 16'd100);
    send_block();
    next_dc(16'd100, e);
    expect_sym("post.dc",  4'd0, e,     1'b1, 1'b0, 1'b0);
    expect_sym("post.eob", 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    wait_done("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
